// File: rtl/gyro_div_scheduler.sv
// gyro_div_scheduler
//   Shares one signed divider between the three gyro axes. Each IMU data-ready
//   edge captures gx/gy/gz, issues rate/DIVISOR for x, y, z in turn and integrates
//   every quotient into pitch/roll/yaw, then pulses ready for one cycle.
//   Configuration macro: GYRO_SAT_EN -- when defined the angle accumulators
//   saturate at the signed limits instead of wrapping modulo 2^WIDTH.
module gyro_div_scheduler #(
  parameter int WIDTH       = 16,
  parameter int DIVISOR     = 10,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic             clk_100mhz,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] gx,
  input  logic [WIDTH-1:0] gy,
  input  logic [WIDTH-1:0] gz,
  input  logic             INT,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic             div_valid,
  output logic [WIDTH-1:0] pitch,
  output logic [WIDTH-1:0] roll,
  output logic [WIDTH-1:0] yaw,
  output logic             ready,
  output logic             overrun,
  output logic             timeout_err
);

  // Timer is one bit wider than strictly needed so DIV_TIMEOUT=1 still works.
  localparam int TIMER_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DIV_TIMEOUT - 1);

`ifdef GYRO_SAT_EN
  localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Angle update: plain two's-complement add, or clamped on signed overflow.
  function automatic logic [WIDTH-1:0] acc_add(input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] inc);
    logic [WIDTH-1:0] sum;
    sum = acc + inc;
`ifdef GYRO_SAT_EN
    // Overflow only when both operands share a sign the result does not.
    return ((acc[WIDTH-1] == inc[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]))
           ? (acc[WIDTH-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    return sum;
`endif
  endfunction

  // Select the captured rate for the axis being divided.
  function automatic logic [WIDTH-1:0] pick_axis(input logic [1:0]       sel,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] z);
    case (sel)
      2'd0:    return x;
      2'd1:    return y;
      2'd2:    return z;
      default: return {WIDTH{1'b0}};
    endcase
  endfunction

  // Reset synchronizer outputs
  logic             rst_meta_r;
  logic             rst_sync_r;
  logic             rst_n_s;

  // INT synchronizer / edge detect
  logic             int_sync1_r;
  logic             int_sync2_r;
  logic             int_sync3_r;
  logic             int_edge_r;

  // FSM
  state_t           state_r;
  state_t           next_state_s;
  logic             capture_s;
  logic             issue_s;
  logic             accept_s;
  logic             timeout_s;
  logic             accum_s;
  logic             last_axis_s;
  logic             overrun_set_s;

  // Datapath
  logic [WIDTH-1:0] cap_x_r;
  logic [WIDTH-1:0] cap_y_r;
  logic [WIDTH-1:0] cap_z_r;
  logic [1:0]       axis_r;
  logic [TIMER_W-1:0] timer_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] div_a_r;
  logic             div_start_r;
  logic [WIDTH-1:0] pitch_r;
  logic [WIDTH-1:0] roll_r;
  logic [WIDTH-1:0] yaw_r;
  logic             ready_r;
  logic             overrun_r;
  logic             timeout_err_r;

  // Reset asserts immediately, deasserts two clock edges after rst_in rises.
  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  assign rst_n_s = rst_sync_r;

  // Bring INT into the clock domain and register a one-cycle rising-edge strobe.
  always_ff @(posedge clk_100mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      int_sync1_r <= 1'b0;
      int_sync2_r <= 1'b0;
      int_sync3_r <= 1'b0;
      int_edge_r  <= 1'b0;
    end else begin
      int_sync1_r <= INT;
      int_sync2_r <= int_sync1_r;
      int_sync3_r <= int_sync2_r;
      int_edge_r  <= int_sync2_r & ~int_sync3_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_100mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  assign last_axis_s   = (axis_r == 2'd2);
  assign overrun_set_s = int_edge_r && (state_r != ST_IDLE);

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    issue_s      = 1'b0;
    accept_s     = 1'b0;
    timeout_s    = 1'b0;
    accum_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (int_edge_r) begin
          capture_s    = 1'b1;
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue_s      = 1'b1;
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the final timer count still wins.
        if (div_valid) begin
          accept_s     = 1'b1;
          next_state_s = ST_ACCUM;
        end else if (timer_r == TIMER_LAST) begin
          timeout_s    = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_ACCUM: begin
        accum_s = 1'b1;
        if (last_axis_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Capture the three rates on the accepting edge and step the axis index.
  always_ff @(posedge clk_100mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      cap_x_r <= {WIDTH{1'b0}};
      cap_y_r <= {WIDTH{1'b0}};
      cap_z_r <= {WIDTH{1'b0}};
      axis_r  <= 2'd0;
    end else begin
      if (capture_s) begin
        cap_x_r <= gx;
        cap_y_r <= gy;
        cap_z_r <= gz;
        axis_r  <= 2'd0;
      end else if (accum_s && !last_axis_s) begin
        axis_r <= axis_r + 2'd1;
      end
    end
  end

  // Divider handshake: request pulse, held dividend, response timer, quotient latch.
  always_ff @(posedge clk_100mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      div_start_r <= 1'b0;
      div_a_r     <= {WIDTH{1'b0}};
      timer_r     <= {TIMER_W{1'b0}};
      q_r         <= {WIDTH{1'b0}};
    end else begin
      div_start_r <= issue_s;
      if (issue_s) begin
        div_a_r <= pick_axis(axis_r, cap_x_r, cap_y_r, cap_z_r);
        timer_r <= {TIMER_W{1'b0}};
      end else if (state_r == ST_WAIT) begin
        timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
      end
      if (accept_s) begin
        q_r <= div_q;
      end
    end
  end

  // Integrate the latched quotient into the angle of the current axis.
  always_ff @(posedge clk_100mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      pitch_r <= {WIDTH{1'b0}};
      roll_r  <= {WIDTH{1'b0}};
      yaw_r   <= {WIDTH{1'b0}};
    end else if (accum_s) begin
      case (axis_r)
        2'd0:    pitch_r <= acc_add(pitch_r, q_r);
        2'd1:    roll_r  <= acc_add(roll_r, q_r);
        2'd2:    yaw_r   <= acc_add(yaw_r, q_r);
        default: pitch_r <= pitch_r;
      endcase
    end
  end

  // Completion pulse (visible during DONE) and sticky error flags.
  always_ff @(posedge clk_100mhz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ready_r       <= 1'b0;
      overrun_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      ready_r <= accum_s & last_axis_s;
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end
      if (timeout_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign div_start   = div_start_r;
  assign div_a       = div_a_r;
  assign div_b       = WIDTH'(DIVISOR);
  assign pitch       = pitch_r;
  assign roll        = roll_r;
  assign yaw         = yaw_r;
  assign ready       = ready_r;
  assign overrun     = overrun_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_gyro_div_scheduler.sv
// Bench for gyro_div_scheduler: a truncating divider model with programmable
// latency, an arithmetic reference model of the integrated angles, and one
// compare process that checks every div_start and every ready pulse.
module tb_gyro_div_scheduler;

  logic        clk_100mhz;
  logic        rst_in;
  logic [15:0] gx, gy, gz;
  logic        INT;
  logic        div_start;
  logic [15:0] div_a, div_b, div_q;
  logic        div_valid;
  logic [15:0] pitch, roll, yaw;
  logic        ready, overrun, timeout_err;

  gyro_div_scheduler #(.WIDTH(16), .DIVISOR(10), .DIV_TIMEOUT(64)) dut (
    .clk_100mhz(clk_100mhz), .rst_in(rst_in),
    .gx(gx), .gy(gy), .gz(gz), .INT(INT),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_valid(div_valid),
    .pitch(pitch), .roll(roll), .yaw(yaw),
    .ready(ready), .overrun(overrun), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // divider model controls
  int  ld          = 4;
  bit  div_alive   = 1'b1;
  bit  force_stray = 1'b0;

  // reference model state
  int          exp_p = 0, exp_r = 0, exp_y = 0;
  logic [15:0] exp_a_q[$];
  int          ready_cnt = 0, ready_cyc = 0;
  int          start_cnt = 0, start_cyc = 0;

  initial begin
    clk_100mhz = 1'b0;
    forever #5 clk_100mhz = ~clk_100mhz;
  end

  initial begin
    forever begin
      @(posedge clk_100mhz);
      cyc++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100mhz);
      #2;
    end
  endtask

  // Angle arithmetic from first principles: 16-bit signed wrap or clamp.
  function automatic int model_acc(input int a, input int q);
    int s;
    s = a + q;
`ifdef GYRO_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`else
    if (s > 32767) s = s - 65536;
    else if (s < -32768) s = s + 65536;
`endif
    return s;
  endfunction

  function automatic int sdiv10(input logic [15:0] v);
    int n;
    n = $signed(v);
    return n / 10;
  endfunction

  task automatic model_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    exp_a_q.push_back(x);
    exp_a_q.push_back(y);
    exp_a_q.push_back(z);
    exp_p = model_acc(exp_p, sdiv10(x));
    exp_r = model_acc(exp_r, sdiv10(y));
    exp_y = model_acc(exp_y, sdiv10(z));
  endtask

  // Shared divider: answers div_start after ld cycles with a truncated quotient.
  initial begin
    bit          pend;
    int          pend_cnt;
    int          pend_n;
    int          pend_d;
    pend = 1'b0; pend_cnt = 0; pend_n = 0; pend_d = 1;
    div_valid = 1'b0;
    div_q = 16'd0;
    forever begin
      @(posedge clk_100mhz);
      #1;
      div_valid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend = 1'b0;
          div_valid = 1'b1;
          div_q = (pend_d != 0) ? 16'(pend_n / pend_d) : 16'd0;
        end
      end
      if (force_stray) begin
        force_stray = 1'b0;
        div_valid = 1'b1;
        div_q = 16'h1234;
      end
      if (div_start && div_alive && rst_in) begin
        pend = 1'b1;
        pend_cnt = ld;
        pend_n = $signed(div_a);
        pend_d = $signed(div_b);
      end
    end
  end

  // Compare process: every request dividend and every ready pulse.
  initial begin
    logic [15:0] ea;
    forever begin
      @(posedge clk_100mhz);
      #1;
      if (rst_in) begin
        if (div_start) begin
          start_cnt++;
          start_cyc = cyc;
          if (exp_a_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL div_start_unexpected: div_a=%0d with no request outstanding", $signed(div_a));
          end else begin
            ea = exp_a_q.pop_front();
            chk("div_a", $signed(div_a), $signed(ea));
          end
        end
        if (ready) begin
          ready_cnt++;
          ready_cyc = cyc;
          chk("ready_pitch", $signed(pitch), exp_p);
          chk("ready_roll", $signed(roll), exp_r);
          chk("ready_yaw", $signed(yaw), exp_y);
        end
      end
    end
  end

  // One complete sample; sync (3) + 3*(3+4)+1 = 25 cycles from INT to ready at Ld=4.
  task automatic run_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input bit check_lat);
    int rc0, t0, w;
    gx = x; gy = y; gz = z;
    model_sample(x, y, z);
    rc0 = ready_cnt;
    t0 = cyc;
    INT = 1'b1;
    tick(4);
    INT = 1'b0;
    tick(2);
    gx = 16'($urandom); gy = 16'($urandom); gz = 16'($urandom);
    w = 0;
    while (ready_cnt == rc0 && w < 400) begin
      tick(1);
      w++;
    end
    if (ready_cnt == rc0) chk("ready_missing", 0, 1);
    else if (check_lat) chk("latency", ready_cyc - t0, 25);
    tick(3);
  endtask

  initial begin
    int rc0, s0, w, t_err;
    rst_in = 1'b0; INT = 1'b0; gx = 16'd0; gy = 16'd0; gz = 16'd0;
    tick(3);
    chk("rst_pitch", $signed(pitch), 0);
    chk("rst_roll", $signed(roll), 0);
    chk("rst_yaw", $signed(yaw), 0);
    chk("rst_ready", ready, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 10);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    rst_in = 1'b1;
    tick(3);

    // directed sample 100, -50, 7
    ld = 4;
    run_sample(16'd100, 16'hFFCE, 16'd7, 1'b1);
    chk("dir_pitch", $signed(pitch), 10);
    chk("dir_roll", $signed(roll), -5);
    chk("dir_yaw", $signed(yaw), 0);

    // ten samples of -15 truncate to -1 each
    for (int i = 0; i < 10; i++) run_sample(16'hFFF1, 16'd0, 16'd0, 1'b1);
    chk("ten_pitch", $signed(pitch), 0);
    chk("ten_roll", $signed(roll), -5);
    chk("ten_yaw", $signed(yaw), 0);

    // second INT while busy
    chk("overrun_pre", overrun, 0);
    rc0 = ready_cnt; s0 = start_cnt;
    gx = 16'd200; gy = 16'd30; gz = 16'hFFD8;
    model_sample(gx, gy, gz);
    INT = 1'b1;
    w = 0;
    while (start_cnt == s0 && w < 50) begin tick(1); w++; end
    INT = 1'b0;
    gx = 16'd999; gy = 16'd999; gz = 16'd999;
    tick(2);
    INT = 1'b1;
    tick(4);
    INT = 1'b0;
    w = 0;
    while (ready_cnt == rc0 && w < 200) begin tick(1); w++; end
    tick(40);
    chk("overrun_ready_count", ready_cnt - rc0, 1);
    chk("overrun_flag", overrun, 1);
    chk("overrun_pitch", $signed(pitch), 20);
    chk("overrun_roll", $signed(roll), -2);
    chk("overrun_yaw", $signed(yaw), -4);

    // dead divider
    chk("timeout_pre", timeout_err, 0);
    div_alive = 1'b0;
    gx = 16'd500; gy = 16'd0; gz = 16'd0;
    exp_a_q.push_back(16'd500);
    rc0 = ready_cnt; s0 = start_cnt;
    INT = 1'b1;
    tick(4);
    INT = 1'b0;
    w = 0;
    while (!timeout_err && w < 300) begin tick(1); w++; end
    t_err = cyc;
    if (!timeout_err) chk("timeout_seen", 0, 1);
    else chk("timeout_delay", t_err - start_cyc, 64);
    tick(20);
    chk("timeout_no_ready", ready_cnt - rc0, 0);
    chk("timeout_one_request", start_cnt - s0, 1);
    chk("timeout_pitch", $signed(pitch), 20);
    div_alive = 1'b1;
    run_sample(16'd40, 16'd0, 16'd0, 1'b1);
    chk("after_timeout_pitch", $signed(pitch), 24);
    chk("timeout_sticky", timeout_err, 1);

    // randomized samples with random divider latency
    for (int i = 0; i < 25; i++) begin
      ld = $urandom_range(8, 1);
      run_sample(16'($urandom), 16'($urandom), 16'($urandom), ld == 4);
    end
    ld = 4;
    chk("rand_pitch", $signed(pitch), exp_p);
    chk("rand_roll", $signed(roll), exp_r);
    chk("rand_yaw", $signed(yaw), exp_y);

    // reset during WAIT, then a stray result
    gx = 16'd1000; gy = 16'd1000; gz = 16'd1000;
    exp_a_q.push_back(16'd1000);
    s0 = start_cnt;
    INT = 1'b1;
    w = 0;
    while (start_cnt == s0 && w < 50) begin tick(1); w++; end
    INT = 1'b0;
    tick(1);
    rst_in = 1'b0;
    tick(1);
    rst_in = 1'b1;
    exp_a_q.delete();
    exp_p = 0; exp_r = 0; exp_y = 0;
    chk("mid_rst_pitch", $signed(pitch), 0);
    chk("mid_rst_roll", $signed(roll), 0);
    chk("mid_rst_yaw", $signed(yaw), 0);
    chk("mid_rst_div_a", div_a, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    rc0 = ready_cnt; s0 = start_cnt;
    force_stray = 1'b1;
    tick(12);
    chk("stray_pitch", $signed(pitch), 0);
    chk("stray_roll", $signed(roll), 0);
    chk("stray_yaw", $signed(yaw), 0);
    chk("stray_ready", ready_cnt - rc0, 0);
    chk("stray_request", start_cnt - s0, 0);

    // drive pitch to the positive limit
    for (int i = 0; i < 11; i++) begin
      run_sample(16'h7FFF, 16'd0, 16'd0, 1'b1);
      if (i == 9) chk("sat_preload", $signed(pitch), 32760);
    end
`ifdef GYRO_SAT_EN
    chk("sat_limit", $signed(pitch), 32767);
`else
    chk("wrap_limit", $signed(pitch), -29500);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
